// File: rtl/dcache_resp.sv
// ============================================================================
// Module      : dcache_resp
// Description : Data-side responder for the EXM stage. Direct-mapped,
//               one-word-per-line, write-through, no-write-allocate cache.
//               Read misses and all stores go out on a req/ack memory port.
// Option      : `define DCACHE_UNCACHED_EN makes addr[31:29]==3'b101 uncached.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   dcache_wdata_bus in   {req, we, wstrb[3:0], addr[31:0], wdata[31:0]}
//   dcache_rdata_bus out  {ready, rvalid, rdata[31:0]}
//   mem_req          out  memory request, held until mem_ack
//   mem_we           out  1 = write, 0 = read
//   mem_addr         out  word-aligned address
//   mem_wstrb        out  byte enables (4'hF on reads)
//   mem_wdata        out  write data
//   mem_ack          in   completes the transaction when high with mem_req
//   mem_rdata        in   read data, valid with mem_ack on a read
// ============================================================================
`default_nettype none

module dcache_resp #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [69:0] dcache_wdata_bus,
  output logic [33:0] dcache_rdata_bus,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int c_lines = 1 << INDEX_W;
  localparam int c_tag_w = 30 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_RESP   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  // Request bus fields
  logic        w_req;
  logic        w_we;
  logic [3:0]  w_wstrb;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_unused;

  assign w_req    = dcache_wdata_bus[69];
  assign w_we     = dcache_wdata_bus[68];
  assign w_wstrb  = dcache_wdata_bus[67:64];
  assign w_addr   = dcache_wdata_bus[63:32];
  assign w_wdata  = dcache_wdata_bus[31:0];
  // Byte offset within the word carries no information for a word cache.
  assign w_unused = ^w_addr[1:0];

  // State and holding registers
  state_t              r_state;
  logic                r_we;
  logic [3:0]          r_wstrb;
  logic [29:0]         r_addr;     // word address, addr[31:2]
  logic [31:0]         r_wdata;
  logic [31:0]         r_refill;

  // Line storage; only the valid bits are reset
  logic [c_lines-1:0]  r_valid;
  logic [c_tag_w-1:0]  r_tag  [c_lines];
  logic [31:0]         r_data [c_lines];

  logic [INDEX_W-1:0]  w_idx;
  logic [c_tag_w-1:0]  w_tag;
  logic                w_cacheable;
  logic                w_hit;
  logic [31:0]         w_merged;
  logic                w_rvalid;
  logic [31:0]         w_rdata;

  assign w_idx = r_addr[INDEX_W-1:0];
  assign w_tag = r_addr[29:INDEX_W];

`ifdef DCACHE_UNCACHED_EN
  // The 0xA000_0000-0xBFFF_FFFF window bypasses the arrays entirely.
  assign w_cacheable = (r_addr[29:27] != 3'b101);
`else
  assign w_cacheable = 1'b1;
`endif

  // An uncached access is forced to look like a miss.
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && w_cacheable;

  // Byte-wise merge of store data into the resident word
  always_comb begin
    w_merged = r_data[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (r_wstrb[b]) begin
        w_merged[8*b +: 8] = r_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM and holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_we     <= 1'b0;
      r_wstrb  <= 4'h0;
      r_addr   <= 30'h0;
      r_wdata  <= 32'h0;
      r_refill <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= w_we;
            r_wstrb <= w_wstrb;
            r_addr  <= w_addr[31:2];
            r_wdata <= w_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (r_we) begin
            r_state <= S_WRITE;
          end else if (w_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_MISS;
          end
        end
        S_MISS: begin
          if (mem_ack) begin
            r_refill <= mem_rdata;
            if (w_cacheable) begin
              r_valid[w_idx] <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; validity is tracked by r_valid alone.
  always_ff @(posedge clk) begin
    if ((r_state == S_MISS) && mem_ack && w_cacheable) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_rdata;
    end else if ((r_state == S_LOOKUP) && r_we && w_hit) begin
      r_data[w_idx] <= w_merged;
    end
  end

  // Response bus: rdata is forced to zero outside the rvalid pulse.
  assign w_rvalid = ((r_state == S_LOOKUP) && !r_we && w_hit) || (r_state == S_RESP);

  always_comb begin
    w_rdata = 32'h0;
    if (r_state == S_RESP) begin
      w_rdata = r_refill;
    end else if (w_rvalid) begin
      w_rdata = r_data[w_idx];
    end
  end

  assign dcache_rdata_bus = {(r_state == S_IDLE), w_rvalid, w_rdata};

  // Memory port, decoded from state so it is stable while mem_req is high
  // and all-zero whenever no transaction is outstanding.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    if (r_state == S_MISS) begin
      mem_req   = 1'b1;
      mem_addr  = {r_addr, 2'b00};
      mem_wstrb = 4'hF;
    end else if (r_state == S_WRITE) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {r_addr, 2'b00};
      mem_wstrb = r_wstrb;
      mem_wdata = r_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_resp.sv
// ============================================================================
// Module      : tb_dcache_resp
// Description : Self-checking bench for dcache_resp. Expected reads and
//               memory transactions are queued at issue time and popped by
//               the response monitor and the memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_resp;

  localparam int INDEX_W = 6;
`ifdef DCACHE_UNCACHED_EN
  localparam bit UNC_EN = 1'b1;
`else
  localparam bit UNC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [69:0] bus;
  logic [33:0] rbus;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dcache_resp #(.INDEX_W(INDEX_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .dcache_wdata_bus (bus),
    .dcache_rdata_bus (rbus),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wstrb        (mem_wstrb),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } mtxn_t;

  mtxn_t       exp_mem[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem_model [logic [31:0]];   // memory as seen by the responder
  logic [31:0] ref_mem   [logic [31:0]];   // memory as predicted by the bench
  bit          ref_valid [64];
  logic [23:0] ref_tag   [64];

  int vectors = 0;
  int miscompares = 0;
  int ack_delay = 0;
  bit hold_ack = 1'b0;
  bit spurious_ack = 1'b0;
  int mem_rd_cnt = 0;
  int mem_wr_cnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_get(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic bit is_unc(input logic [31:0] a);
    return UNC_EN && (a[31:29] == 3'b101);
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    int    wait_cnt;
    mtxn_t act;
    mtxn_t exp;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      if (!reset) begin
        wait_cnt = 0;
      end else if (mem_req && !hold_ack) begin
        if (wait_cnt >= ack_delay) begin
          wait_cnt = 0;
          act = '{we: mem_we, addr: mem_addr, strb: mem_wstrb, data: (mem_we ? mem_wdata : 32'h0)};
          vectors++;
          if (exp_mem.size() == 0) begin
            miscompares++;
            $display("FAIL mem_txn_unexpected got we=%0b addr=%h strb=%h data=%h", act.we, act.addr, act.strb, act.data);
          end else begin
            exp = exp_mem.pop_front();
            if (act !== exp) begin
              miscompares++;
              $display("FAIL mem_txn got we=%0b addr=%h strb=%h data=%h want we=%0b addr=%h strb=%h data=%h",
                       act.we, act.addr, act.strb, act.data, exp.we, exp.addr, exp.strb, exp.data);
            end
          end
          if (mem_we) begin
            mem_model[mem_addr] = merge(model_get(mem_addr), mem_wdata, mem_wstrb);
            mem_wr_cnt++;
          end else begin
            mem_rdata = model_get(mem_addr);
            mem_rd_cnt++;
          end
          mem_ack = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else if (!mem_req && spurious_ack) begin
        mem_ack      = 1'b1;
        mem_rdata    = 32'hBAD0_BAD0;
        spurious_ack = 1'b0;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        vectors++;
        if (rbus[32]) begin
          if (exp_rd.size() == 0) begin
            miscompares++;
            $display("FAIL rvalid_unexpected got rdata=%h", rbus[31:0]);
          end else begin
            e = exp_rd.pop_front();
            if (rbus[31:0] !== e) begin
              miscompares++;
              $display("FAIL rdata got=%h want=%h", rbus[31:0], e);
            end
          end
        end else if (rbus[31:0] !== 32'h0) begin
          miscompares++;
          $display("FAIL rdata_idle got=%h want=00000000", rbus[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request, wait for acceptance, then scramble the bus.
  // Returns 1ns after the accepting edge and records the prediction.
  task automatic issue(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int          n = 0;
    logic [31:0] wa;
    logic [5:0]  idx;
    logic [23:0] tg;
    bit          hit;
    wa  = {addr[31:2], 2'b00};
    idx = addr[7:2];
    tg  = addr[31:8];
    @(negedge clk);
    while (rbus[33] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout got ready=%b want 1", rbus[33]);
    end
    bus = {1'b1, we, strb, addr, wdata};
    @(posedge clk);
    #1;
    bus = {1'b0, 5'($urandom), 32'($urandom), 32'($urandom)};
    if (we) begin
      exp_mem.push_back('{we: 1'b1, addr: wa, strb: strb, data: wdata});
      ref_mem[wa] = merge(ref_get(wa), wdata, strb);
    end else begin
      hit = ref_valid[idx] && (ref_tag[idx] == tg) && !is_unc(addr);
      exp_rd.push_back(ref_get(wa));
      if (!hit) begin
        exp_mem.push_back('{we: 1'b0, addr: wa, strb: 4'hF, data: 32'h0});
        if (!is_unc(addr)) begin
          ref_valid[idx] = 1'b1;
          ref_tag[idx]   = tg;
        end
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!(rbus[33] === 1'b1 && exp_mem.size() == 0 && exp_rd.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL completion_timeout got ready=%b pend_mem=%0d pend_rd=%0d want 1/0/0",
               rbus[33], exp_mem.size(), exp_rd.size());
      exp_mem.delete();
      exp_rd.delete();
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    @(negedge clk);
    #1;
    while (mem_ack !== 1'b1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout got mem_req=%b want ack", mem_req);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rbus, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {2'b10, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_outputs got rbus=%h req=%b we=%b addr=%h strb=%h wdata=%h want rbus=200000000 rest 0",
               rbus, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_cold_read();
    int r0 = mem_rd_cnt;
    ack_delay = 2;
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    vectors++;
    if (mem_req !== 1'b0 || rbus[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_lookup_cycle got req=%b rvalid=%b want 0/0", mem_req, rbus[32]);
    end
    @(posedge clk); #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h40, 4'hF}) begin
      miscompares++;
      $display("FAIL miss_mem_req got req=%b we=%b addr=%h strb=%h want 1/0/00000040/f",
               mem_req, mem_we, mem_addr, mem_wstrb);
    end
    wait_ack();
    @(posedge clk); #1;
    vectors++;
    if (rbus[32] !== 1'b1 || rbus[31:0] !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL refill_resp got rvalid=%b rdata=%h req=%b want 1/deadbeef/0", rbus[32], rbus[31:0], mem_req);
    end
    @(posedge clk); #1;
    vectors++;
    if (rbus[33] !== 1'b1 || rbus[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL refill_ready got ready=%b rvalid=%b want 1/0", rbus[33], rbus[32]);
    end
    wait_done();
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    vectors++;
    if (rbus[32] !== 1'b1 || rbus[31:0] !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_resp got rvalid=%b rdata=%h req=%b want 1/deadbeef/0", rbus[32], rbus[31:0], mem_req);
    end
    @(posedge clk); #1;
    vectors++;
    if (rbus[33] !== 1'b1 || rbus[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_ready got ready=%b rvalid=%b want 1/0", rbus[33], rbus[32]);
    end
    wait_done();
    vectors++;
    if (mem_rd_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL cold_read_memreads got=%0d want=1", mem_rd_cnt - r0);
    end
  endtask

  task automatic test_write_hit();
    ack_delay = 1;
    issue(1'b1, 4'b0011, 32'h0000_0040, 32'h1122_3344);
    vectors++;
    if (mem_req !== 1'b0 || rbus[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL write_lookup got req=%b rvalid=%b want 0/0", mem_req, rbus[32]);
    end
    @(posedge clk); #1;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 1'b1, 32'h40, 4'b0011, 32'h1122_3344}) begin
      miscompares++;
      $display("FAIL write_mem_req got req=%b we=%b addr=%h strb=%h wdata=%h want 1/1/00000040/3/11223344",
               mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    wait_ack();
    @(posedge clk); #1;
    vectors++;
    if (rbus[33] !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL write_ready got ready=%b req=%b want 1/0", rbus[33], mem_req);
    end
    wait_done();
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    vectors++;
    if (rbus[32] !== 1'b1 || rbus[31:0] !== 32'hDEAD_3344) begin
      miscompares++;
      $display("FAIL write_hit_merge got rvalid=%b rdata=%h want 1/dead3344", rbus[32], rbus[31:0]);
    end
    wait_done();
  endtask

  task automatic test_write_miss();
    int r0;
    ack_delay = 0;
    issue(1'b1, 4'hF, 32'h0000_0080, 32'hAAAA_5555);
    wait_done();
    r0 = mem_rd_cnt;
    issue(1'b0, 4'hF, 32'h0000_0080, 32'h0);
    wait_done();
    vectors++;
    if (mem_rd_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL no_allocate_memreads got=%0d want=1", mem_rd_cnt - r0);
    end
  endtask

  task automatic test_wstrb_zero();
    int r0;
    issue(1'b1, 4'h0, 32'h0000_0040, 32'hFFFF_FFFF);
    wait_done();
    r0 = mem_rd_cnt;
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    vectors++;
    if (rbus[32] !== 1'b1 || rbus[31:0] !== 32'hDEAD_3344) begin
      miscompares++;
      $display("FAIL wstrb_zero_data got rvalid=%b rdata=%h want 1/dead3344", rbus[32], rbus[31:0]);
    end
    wait_done();
    vectors++;
    if (mem_rd_cnt !== r0) begin
      miscompares++;
      $display("FAIL wstrb_zero_memreads got=%0d want=0", mem_rd_cnt - r0);
    end
  endtask

  task automatic test_conflict();
    int r0 = mem_rd_cnt;
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    wait_done();
    issue(1'b0, 4'hF, 32'h0000_0140, 32'h0);
    wait_done();
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    wait_done();
    vectors++;
    if (mem_rd_cnt - r0 !== 2) begin
      miscompares++;
      $display("FAIL conflict_memreads got=%0d want=2", mem_rd_cnt - r0);
    end
  endtask

  task automatic test_reset_in_miss();
    int r0;
    hold_ack = 1'b1;
    issue(1'b0, 4'hF, 32'h0000_0200, 32'h0);
    @(posedge clk); #1;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL held_miss_req got=%b want=1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || rbus[33] !== 1'b1 || rbus[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got req=%b ready=%b rvalid=%b want 0/1/0", mem_req, rbus[33], rbus[32]);
    end
    exp_mem.delete();
    exp_rd.delete();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    r0 = mem_rd_cnt;
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    wait_done();
    vectors++;
    if (mem_rd_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL post_reset_miss got memreads=%0d want=1", mem_rd_cnt - r0);
    end
  endtask

  task automatic test_spurious_ack();
    spurious_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (rbus[33] !== 1'b1 || mem_req !== 1'b0 || rbus[32] !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_ack got ready=%b req=%b rvalid=%b want 1/0/0", rbus[33], mem_req, rbus[32]);
    end
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    wait_done();
  endtask

  task automatic test_uncached();
    int r0 = mem_rd_cnt;
    issue(1'b0, 4'hF, 32'hA000_0000, 32'h0);
    wait_done();
    issue(1'b0, 4'hF, 32'hA000_0000, 32'h0);
    wait_done();
    vectors++;
    if (mem_rd_cnt - r0 !== (UNC_EN ? 2 : 1)) begin
      miscompares++;
      $display("FAIL uncached_memreads got=%0d want=%0d", mem_rd_cnt - r0, (UNC_EN ? 2 : 1));
    end
  endtask

  task automatic test_back_to_back();
    time t_prev;
    time t_now;
    issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
    t_prev = $time;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 4'hF, 32'h0000_0040, 32'h0);
      t_now = $time;
      vectors++;
      if (t_now - t_prev !== 20) begin
        miscompares++;
        $display("FAIL hit_throughput got=%0t want=20", t_now - t_prev);
      end
      t_prev = t_now;
    end
    wait_done();
  endtask

  task automatic test_random();
    logic [31:0] addrs [8];
    addrs[0] = 32'h0000_0040; addrs[1] = 32'h0000_0140; addrs[2] = 32'h0000_0044;
    addrs[3] = 32'h0000_0080; addrs[4] = 32'h0000_0240; addrs[5] = 32'h1000_0040;
    addrs[6] = 32'hA000_0004; addrs[7] = 32'h0000_0FFC;
    for (int i = 0; i < 60; i++) begin
      ack_delay = int'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 2) == 0), 4'($urandom), addrs[$urandom_range(0, 7)], $urandom);
    end
    wait_done();
  endtask

  initial begin : main
    bus = 70'h0;
    mem_model[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40]   = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 24'h0;
    end
    test_reset();
    test_cold_read();
    test_write_hit();
    test_write_miss();
    test_wstrb_zero();
    test_conflict();
    test_reset_in_miss();
    test_spurious_ack();
    test_uncached();
    test_back_to_back();
    test_random();
    vectors++;
    if (exp_mem.size() != 0 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations got mem=%0d rd=%0d want 0/0", exp_mem.size(), exp_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_resp.md
# dcache_resp

Data-side responder that terminates the load/store request bus issued by the execute/memory stage and returns the `{ready, rvalid, rdata}` response bus that stage consumes. It is a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache. Misses and all stores are forwarded to a simple req/ack memory port. It sits between EXM_stage (`dcache_wdata_bus` → here → `dcache_rdata_bus`) and the memory/bus bridge.

## Interface
- INDEX_W, 6, index bits; the cache has 2^INDEX_W lines, each one 32-bit word; tag width is 30-INDEX_W.
- clk  in  1  clock; everything samples on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- dcache_wdata_bus  in  70  request from EXM: {req[69], we[68], wstrb[67:64], addr[63:32], wdata[31:0]}; addr[1:0] ignored.
- dcache_rdata_bus  out  34  response to EXM: {ready[33], rvalid[32], rdata[31:0]}.
- mem_req  out  1  memory transaction request, held until acknowledged.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wstrb  out  4  byte enables for writes; 4'hF for reads.
- mem_wdata  out  32  write data.
- mem_ack  in  1  completes the transaction in the cycle it is high with mem_req.
- mem_rdata  in  32  read data, valid when mem_ack is high on a read.

## Operation
- Storage: valid[2^INDEX_W], tag[2^INDEX_W], data[2^INDEX_W] flop arrays. Index = addr[INDEX_W+1:2]; tag = addr[31:INDEX_W+2].
- Request latch: a request is accepted when req=1 and ready=1. we/wstrb/addr/wdata are captured into holding registers. After acceptance the bus may change freely.
- FSM states:
  - IDLE: ready=1.
    - Accepted request → LOOKUP.
  - LOOKUP: ready=0. hit = valid[idx] && tag[idx]==tag.
    - Read hit: rvalid=1, rdata=data[idx] → IDLE.
    - Read miss → MISS.
    - Write hit: merge wdata into data[idx] byte-wise per wstrb → WRITE.
    - Write miss: no change to the arrays → WRITE.
  - MISS: mem_req=1, mem_we=0.
    - On mem_ack: valid/tag/data[idx] ← 1/tag/mem_rdata; latch mem_rdata → RESP.
  - RESP: rvalid=1, rdata=latched refill word → IDLE.
  - WRITE: mem_req=1, mem_we=1, mem_wstrb=wstrb, mem_wdata=wdata.
    - On mem_ack → IDLE.
    - Stores never assert rvalid.
- mem_* outputs are driven combinationally from state and holding registers. They are stable while mem_req=1.
- wstrb=4'h0 on a write: still issued to memory with strobe 0; no array change.
- req arriving while ready=0 is ignored. The requester must hold it until it sees ready=1.
- rvalid is a single-cycle pulse. rdata is 32'b0 whenever rvalid=0.

## Timing
- Reset (asserted low, asynchronous):
  - State goes to IDLE and all valid bits clear.
  - ready=1, rvalid=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
  - Tag and data arrays are not reset.
- Read hit: accept in cycle N, rvalid in N+1, ready=1 again in N+2. Throughput is one hit per 2 cycles.
- Read miss: mem_req rises in N+2. If mem_ack arrives in cycle M, rvalid is in M+1 and ready in M+2.
- Write: mem_req rises in N+2. If acked in M, ready is in M+1.
- mem_ack in the first cycle of mem_req is legal. mem_ack while mem_req=0 is ignored.
- Reset during MISS/WRITE drops mem_req immediately. The memory side must tolerate the abandoned transaction, and no line is filled.
- A refill to an index overwrites that line unconditionally; no write-back is ever needed.

## Configuration
- DCACHE_UNCACHED_EN:
  - When defined, requests with addr[31:29]==3'b101 are uncached.
    - Uncached reads go LOOKUP→MISS regardless of hit, and the refill does not write the arrays.
    - Uncached writes never update the arrays.
  - When undefined, all addresses are cacheable and that decode logic is absent.

## Test plan
- Cold read at 0x0000_0040 → mem_req with mem_addr=0x40, mem_we=0. Ack with mem_rdata=0xDEAD_BEEF → rvalid pulse with rdata=0xDEAD_BEEF. A repeat read gives rvalid 1 cycle after acceptance with no mem_req.
- Write hit to 0x40, wdata=0x1122_3344, wstrb=4'b0011 → mem write with the same strb/data. A subsequent read hit returns 0xDEAD_3344.
- Write miss to 0x80 → mem write issued. A later read of 0x80 still misses, showing no allocate.
- Conflict with INDEX_W=6: read 0x40, then read 0x140 → second read misses and refills. A third read of 0x40 misses again.
- Reset low during MISS with ack withheld → mem_req=0 and ready=1 asynchronously. After release, read 0x40 misses.
- With DCACHE_UNCACHED_EN defined, read 0xA000_0000 twice → two mem reads and no hit. Without the macro, the second read hits.
